// File: rtl/ikun_multi_target_detect_p_if.sv
// AXI4-Stream video mask link feeding the multi-target detector.
// The master drives pixels; the slave answers with tready.
interface ikun_multi_target_detect_p_if;
    logic s_axis_video_tdata;
    logic s_axis_video_tvalid;
    logic s_axis_video_tready;
    logic s_axis_video_tlast;
    logic s_axis_video_tuser;

    modport master (
        output s_axis_video_tdata,
        output s_axis_video_tvalid,
        output s_axis_video_tlast,
        output s_axis_video_tuser,
        input  s_axis_video_tready
    );

    modport slave (
        input  s_axis_video_tdata,
        input  s_axis_video_tvalid,
        input  s_axis_video_tlast,
        input  s_axis_video_tuser,
        output s_axis_video_tready
    );
endinterface

// File: rtl/ikun_multi_target_detect_p.sv
// Clusters foreground pixels of a binary motion mask into bounding boxes, merges
// overlapping boxes at end of frame, filters by size and publishes a compact list.
module ikun_multi_target_detect_p #(
    parameter int IMG_HDISP   = 1280,
    parameter int IMG_VDISP   = 720,
    parameter int CW          = 12,
    parameter int MAX_TARGETS = 16,
    parameter int MIN_DIST    = 30,
    parameter int MIN_W       = 1,
    parameter int MIN_H       = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    ikun_multi_target_detect_p_if.slave           s_axis,
    output logic [MAX_TARGETS*(4*CW+1)-1:0]       target_pos_out,
    output logic [$clog2(MAX_TARGETS+1)-1:0]      target_num_out,
    output logic                                  target_pos_valid,
    output logic                                  target_overflow,
    output logic                                  frame_busy
);
    localparam int EW = 4*CW+1;
    localparam int NW = $clog2(MAX_TARGETS+1);
    localparam int IW = $clog2(MAX_TARGETS);
    localparam logic [CW:0]   DIST = (CW+1)'(MIN_DIST);
    localparam logic [CW:0]   XLIM = (CW+1)'(IMG_HDISP-1);
    localparam logic [CW:0]   YLIM = (CW+1)'(IMG_VDISP-1);
    localparam logic [CW:0]   MINW = (CW+1)'(MIN_W);
    localparam logic [CW:0]   MINH = (CW+1)'(MIN_H);
    localparam logic [NW-1:0] FULL = NW'(MAX_TARGETS);

    typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, MERGE, EMIT, DONE} state_t;

    state_t                 state_q;
    logic                   ready_q;
    logic [CW-1:0]          x_q;
    logic [CW-1:0]          y_q;
    logic [MAX_TARGETS-1:0] entValid_q;
    logic [CW-1:0]          xMin_q [MAX_TARGETS];
    logic [CW-1:0]          yMin_q [MAX_TARGETS];
    logic [CW-1:0]          xMax_q [MAX_TARGETS];
    logic [CW-1:0]          yMax_q [MAX_TARGETS];
    logic [NW-1:0]          count_q;
    logic                   ovf_q;
    logic                   s2Valid_q;
    logic [CW-1:0]          s2X_q;
    logic [CW-1:0]          s2Y_q;
    logic [MAX_TARGETS-1:0] s2Votes_q;
    logic                   drain_q;
    logic [IW-1:0]          mi_q;
    logic [IW-1:0]          mj_q;
    logic [IW-1:0]          ei_q;
    logic [NW-1:0]          emitN_q;
    logic [EW-1:0]          shadow_q [MAX_TARGETS];

    logic                   accept_d;
    logic                   sof_d;
    logic                   inFrame_d;
    logic                   eof_d;
    logic [CW-1:0]          pixX_d;
    logic [CW-1:0]          pixY_d;
    logic [MAX_TARGETS-1:0] votes_d;
    logic                   overlap_d;
    logic                   lastJ_d;
    logic                   lastI_d;
    logic                   lastE_d;
    logic                   keep_d;
    logic [CW-1:0]          uXMin_d;
    logic [CW-1:0]          uYMin_d;
    logic [CW-1:0]          uXMax_d;
    logic [CW-1:0]          uYMax_d;

    // Dilated box test done one bit wider so neither the subtraction nor the addition wraps.
    function automatic logic outsideBox(input logic [CW-1:0] px, input logic [CW-1:0] py,
                                        input logic [CW-1:0] bx0, input logic [CW-1:0] by0,
                                        input logic [CW-1:0] bx1, input logic [CW-1:0] by1);
        logic [CW:0] lx;
        logic [CW:0] hx;
        logic [CW:0] ly;
        logic [CW:0] hy;
        lx = ({1'b0, bx0} >= DIST) ? ({1'b0, bx0} - DIST) : '0;
        ly = ({1'b0, by0} >= DIST) ? ({1'b0, by0} - DIST) : '0;
        hx = (({1'b0, bx1} + DIST) > XLIM) ? XLIM : ({1'b0, bx1} + DIST);
        hy = (({1'b0, by1} + DIST) > YLIM) ? YLIM : ({1'b0, by1} + DIST);
        return ({1'b0, px} < lx) || ({1'b0, px} > hx) ||
               ({1'b0, py} < ly) || ({1'b0, py} > hy);
    endfunction

    assign s_axis.s_axis_video_tready = ready_q;
    assign frame_busy = (state_q == DRAIN) || (state_q == MERGE) || (state_q == EMIT);

    always_comb begin
        accept_d  = s_axis.s_axis_video_tvalid & ready_q;
        sof_d     = accept_d & s_axis.s_axis_video_tuser;
        inFrame_d = accept_d & (sof_d | (state_q == COLLECT));
        pixX_d    = sof_d ? '0 : x_q;
        pixY_d    = sof_d ? '0 : y_q;
        eof_d     = inFrame_d & s_axis.s_axis_video_tlast & (pixY_d == YLIM[CW-1:0]);
        votes_d   = '0;
        for (int k = 0; k < MAX_TARGETS; k++) begin
            votes_d[k] = sof_d | ~entValid_q[k] |
                         outsideBox(pixX_d, pixY_d, xMin_q[k], yMin_q[k], xMax_q[k], yMax_q[k]);
        end
    end

    // Merge compares raw boxes, without the clustering radius.
    always_comb begin
        overlap_d = entValid_q[mi_q] & entValid_q[mj_q] &
                    !((xMin_q[mi_q] > xMax_q[mj_q]) || (xMax_q[mi_q] < xMin_q[mj_q]) ||
                      (yMin_q[mi_q] > yMax_q[mj_q]) || (yMax_q[mi_q] < yMin_q[mj_q]));
        uXMin_d = (xMin_q[mi_q] < xMin_q[mj_q]) ? xMin_q[mi_q] : xMin_q[mj_q];
        uYMin_d = (yMin_q[mi_q] < yMin_q[mj_q]) ? yMin_q[mi_q] : yMin_q[mj_q];
        uXMax_d = (xMax_q[mi_q] > xMax_q[mj_q]) ? xMax_q[mi_q] : xMax_q[mj_q];
        uYMax_d = (yMax_q[mi_q] > yMax_q[mj_q]) ? yMax_q[mi_q] : yMax_q[mj_q];
        lastJ_d = (NW'(mj_q) + NW'(1)) >= count_q;
        lastI_d = (NW'(mi_q) + NW'(2)) >= count_q;
        lastE_d = (NW'(ei_q) + NW'(1)) >= count_q;
        keep_d  = (NW'(ei_q) < count_q) & entValid_q[ei_q] &
                  (({1'b0, xMax_q[ei_q]} - {1'b0, xMin_q[ei_q]} + (CW+1)'(1)) >= MINW) &
                  (({1'b0, yMax_q[ei_q]} - {1'b0, yMin_q[ei_q]} + (CW+1)'(1)) >= MINH);
    end

    // Pixel counters, the two-stage clustering pipeline and the frame FSM share one register block
    // because start-of-frame clearing must override a pending stage-2 update in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            ready_q          <= 1'b0;
            x_q              <= '0;
            y_q              <= '0;
            entValid_q       <= '0;
            count_q          <= '0;
            ovf_q            <= 1'b0;
            s2Valid_q        <= 1'b0;
            s2X_q            <= '0;
            s2Y_q            <= '0;
            s2Votes_q        <= '0;
            drain_q          <= 1'b0;
            mi_q             <= '0;
            mj_q             <= '0;
            ei_q             <= '0;
            emitN_q          <= '0;
            target_pos_out   <= '0;
            target_num_out   <= '0;
            target_pos_valid <= 1'b0;
            target_overflow  <= 1'b0;
            for (int k = 0; k < MAX_TARGETS; k++) begin
                xMin_q[k]   <= '0;
                yMin_q[k]   <= '0;
                xMax_q[k]   <= '0;
                yMax_q[k]   <= '0;
                shadow_q[k] <= '0;
            end
        end else begin
            target_pos_valid <= 1'b0;

            if (inFrame_d) begin
                if (s_axis.s_axis_video_tlast) begin
                    x_q <= '0;
                    y_q <= pixY_d + CW'(1);
                end else begin
                    x_q <= pixX_d + CW'(1);
                    y_q <= pixY_d;
                end
            end

            if (s2Valid_q) begin
                if (&s2Votes_q) begin
                    if (count_q < FULL) begin
                        entValid_q[count_q[IW-1:0]] <= 1'b1;
                        xMin_q[count_q[IW-1:0]]     <= s2X_q;
                        xMax_q[count_q[IW-1:0]]     <= s2X_q;
                        yMin_q[count_q[IW-1:0]]     <= s2Y_q;
                        yMax_q[count_q[IW-1:0]]     <= s2Y_q;
                        count_q                     <= count_q + NW'(1);
                    end else begin
                        ovf_q <= 1'b1;
                    end
                end else begin
                    for (int k = 0; k < MAX_TARGETS; k++) begin
                        if (!s2Votes_q[k]) begin
                            if (s2X_q < xMin_q[k]) xMin_q[k] <= s2X_q;
                            if (s2X_q > xMax_q[k]) xMax_q[k] <= s2X_q;
                            if (s2Y_q < yMin_q[k]) yMin_q[k] <= s2Y_q;
                            if (s2Y_q > yMax_q[k]) yMax_q[k] <= s2Y_q;
                        end
                    end
                end
            end

            s2Valid_q <= inFrame_d & s_axis.s_axis_video_tdata;
            s2X_q     <= pixX_d;
            s2Y_q     <= pixY_d;
            s2Votes_q <= votes_d;

            if (sof_d) begin
                entValid_q <= '0;
                count_q    <= '0;
                ovf_q      <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (sof_d) state_q <= COLLECT;
                end
                COLLECT: begin
                    ready_q <= 1'b1;
                end
                DRAIN: begin
                    if (!drain_q) begin
                        drain_q <= 1'b1;
                    end else begin
                        drain_q <= 1'b0;
                        emitN_q <= '0;
                        ei_q    <= '0;
                        mi_q    <= '0;
                        mj_q    <= IW'(1);
                        for (int k = 0; k < MAX_TARGETS; k++) shadow_q[k] <= '0;
                        state_q <= (count_q <= NW'(1)) ? EMIT : MERGE;
                    end
                end
                MERGE: begin
                    if (overlap_d) begin
                        xMin_q[mj_q]     <= uXMin_d;
                        yMin_q[mj_q]     <= uYMin_d;
                        xMax_q[mj_q]     <= uXMax_d;
                        yMax_q[mj_q]     <= uYMax_d;
                        entValid_q[mi_q] <= 1'b0;
                    end
                    if (overlap_d || lastJ_d) begin
                        if (lastI_d) begin
                            state_q <= EMIT;
                        end else begin
                            mi_q <= mi_q + IW'(1);
                            mj_q <= mi_q + IW'(2);
                        end
                    end else begin
                        mj_q <= mj_q + IW'(1);
                    end
                end
                EMIT: begin
                    if (keep_d) begin
                        shadow_q[emitN_q[IW-1:0]] <= {1'b1, yMax_q[ei_q], xMax_q[ei_q],
                                                      yMin_q[ei_q], xMin_q[ei_q]};
                        emitN_q <= emitN_q + NW'(1);
                    end
                    if (lastE_d) state_q <= DONE;
                    else         ei_q    <= ei_q + IW'(1);
                end
                DONE: begin
                    for (int k = 0; k < MAX_TARGETS; k++) target_pos_out[k*EW +: EW] <= shadow_q[k];
                    target_num_out   <= emitN_q;
                    target_overflow  <= ovf_q;
                    target_pos_valid <= 1'b1;
                    ready_q          <= 1'b1;
                    state_q          <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // The last line's final beat closes the frame; input stalls until the list is published.
            if (eof_d) begin
                state_q <= DRAIN;
                ready_q <= 1'b0;
                drain_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ikun_multi_target_detect_p.sv
// Directed and randomized frames for the multi-target detector, checked against a
// pixel-level reference model of clustering, merge and size filtering.
module tb_ikun_multi_target_detect_p;
    localparam int W    = 64;
    localparam int H    = 32;
    localparam int MAXT = 4;
    localparam int MD   = 2;
    localparam int CW   = 7;
    localparam int EW   = 4*CW+1;
    localparam int NW   = $clog2(MAXT+1);

    logic clk = 1'b0;
    logic rst;
    logic tdata, tvalid, tlast, tuser;

    logic [MAXT*EW-1:0] posA, posB;
    logic [NW-1:0]      numA, numB;
    logic               validA, validB, ovfA, ovfB, busyA, busyB;
    logic               readyA, readyB;

    ikun_multi_target_detect_p_if axisA ();
    ikun_multi_target_detect_p_if axisB ();

    assign axisA.s_axis_video_tdata  = tdata;
    assign axisA.s_axis_video_tvalid = tvalid;
    assign axisA.s_axis_video_tlast  = tlast;
    assign axisA.s_axis_video_tuser  = tuser;
    assign axisB.s_axis_video_tdata  = tdata;
    assign axisB.s_axis_video_tvalid = tvalid;
    assign axisB.s_axis_video_tlast  = tlast;
    assign axisB.s_axis_video_tuser  = tuser;
    assign readyA = axisA.s_axis_video_tready;
    assign readyB = axisB.s_axis_video_tready;

    ikun_multi_target_detect_p #(
        .IMG_HDISP(W), .IMG_VDISP(H), .CW(CW), .MAX_TARGETS(MAXT),
        .MIN_DIST(MD), .MIN_W(1), .MIN_H(1)
    ) dutA (
        .clk(clk), .rst(rst), .s_axis(axisA.slave),
        .target_pos_out(posA), .target_num_out(numA), .target_pos_valid(validA),
        .target_overflow(ovfA), .frame_busy(busyA)
    );

    ikun_multi_target_detect_p #(
        .IMG_HDISP(W), .IMG_VDISP(H), .CW(CW), .MAX_TARGETS(MAXT),
        .MIN_DIST(MD), .MIN_W(3), .MIN_H(1)
    ) dutB (
        .clk(clk), .rst(rst), .s_axis(axisB.slave),
        .target_pos_out(posB), .target_num_out(numB), .target_pos_valid(validB),
        .target_overflow(ovfB), .frame_busy(busyB)
    );

    always #5 clk = ~clk;

    int pulsesA = 0;
    int pulsesB = 0;
    always @(negedge clk) begin
        if (validA === 1'b1) pulsesA <= pulsesA + 1;
        if (validB === 1'b1) pulsesB <= pulsesB + 1;
    end

    int nAssert = 0;
    int nFail   = 0;
    int cyc     = 0;
    bit readyBad;
    bit mask [H][W];

    // Reference model state: box list plus the one pixel still waiting to be applied.
    int mV [MAXT];
    int mX0 [MAXT];
    int mY0 [MAXT];
    int mX1 [MAXT];
    int mY1 [MAXT];
    int mCnt, mOvf;
    bit pend;
    int pendX, pendY, pendCyc;
    bit [MAXT-1:0] pendVotes;
    logic [EW-1:0] expPos [2][MAXT];
    int expNum [2];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < MAXT; k++) mV[k] = 0;
        mCnt = 0;
        mOvf = 0;
        pend = 0;
    endtask

    function automatic bit modelVote(int k, int x, int y);
        int lx, hx, ly, hy;
        if (!mV[k]) return 1'b1;
        lx = (mX0[k] - MD < 0) ? 0 : mX0[k] - MD;
        ly = (mY0[k] - MD < 0) ? 0 : mY0[k] - MD;
        hx = (mX1[k] + MD > W-1) ? W-1 : mX1[k] + MD;
        hy = (mY1[k] + MD > H-1) ? H-1 : mY1[k] + MD;
        return (x < lx) || (x > hx) || (y < ly) || (y > hy);
    endfunction

    task automatic modelApply();
        if (!pend) return;
        pend = 0;
        if (&pendVotes) begin
            if (mCnt < MAXT) begin
                mV[mCnt] = 1; mX0[mCnt] = pendX; mX1[mCnt] = pendX;
                mY0[mCnt] = pendY; mY1[mCnt] = pendY;
                mCnt++;
            end else begin
                mOvf = 1;
            end
        end else begin
            for (int k = 0; k < MAXT; k++) begin
                if (!pendVotes[k]) begin
                    if (pendX < mX0[k]) mX0[k] = pendX;
                    if (pendX > mX1[k]) mX1[k] = pendX;
                    if (pendY < mY0[k]) mY0[k] = pendY;
                    if (pendY > mY1[k]) mY1[k] = pendY;
                end
            end
        end
    endtask

    // A pixel sees every earlier pixel except the one accepted on the immediately preceding cycle.
    task automatic modelBeat(int c, bit fg, int x, int y, bit sof);
        bit [MAXT-1:0] v;
        if (sof) modelReset();
        else if (pend && pendCyc + 1 < c) modelApply();
        for (int k = 0; k < MAXT; k++) v[k] = modelVote(k, x, y);
        modelApply();
        if (fg) begin
            pend = 1; pendX = x; pendY = y; pendVotes = v; pendCyc = c;
        end
    endtask

    task automatic modelFinish();
        int n;
        int minW;
        modelApply();
        for (int i = 0; i < mCnt - 1; i++) begin
            for (int j = i + 1; j < mCnt; j++) begin
                if (mV[i] && mV[j] && !(mX0[i] > mX1[j] || mX1[i] < mX0[j] ||
                                        mY0[i] > mY1[j] || mY1[i] < mY0[j])) begin
                    mX0[j] = (mX0[i] < mX0[j]) ? mX0[i] : mX0[j];
                    mY0[j] = (mY0[i] < mY0[j]) ? mY0[i] : mY0[j];
                    mX1[j] = (mX1[i] > mX1[j]) ? mX1[i] : mX1[j];
                    mY1[j] = (mY1[i] > mY1[j]) ? mY1[i] : mY1[j];
                    mV[i] = 0;
                    break;
                end
            end
        end
        for (int s = 0; s < 2; s++) begin
            minW = (s == 0) ? 1 : 3;
            n = 0;
            for (int k = 0; k < MAXT; k++) expPos[s][k] = '0;
            for (int k = 0; k < mCnt; k++) begin
                if (mV[k] && (mX1[k] - mX0[k] + 1) >= minW && (mY1[k] - mY0[k] + 1) >= 1) begin
                    expPos[s][n] = {1'b1, CW'(mY1[k]), CW'(mX1[k]), CW'(mY0[k]), CW'(mX0[k])};
                    n++;
                end
            end
            expNum[s] = n;
        end
    endtask

    task automatic clearMask();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) mask[y][x] = 1'b0;
    endtask

    task automatic addRect(int x0, int y0, int x1, int y1);
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) mask[y][x] = 1'b1;
    endtask

    // Streams the first 'lines' lines of the mask, with random idle cycles when gapPct > 0.
    task automatic applyStimulus(int lines, int gapPct);
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < W; x++) begin
                while (gapPct > 0 && int'($urandom_range(99)) < gapPct) begin
                    @(negedge clk);
                    tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; tdata = 1'b0;
                    cyc++;
                end
                @(negedge clk);
                tvalid = 1'b1;
                tdata  = mask[y][x];
                tuser  = (x == 0 && y == 0);
                tlast  = (x == W-1);
                if (readyA !== 1'b1 || readyB !== 1'b1) readyBad = 1'b1;
                modelBeat(cyc, mask[y][x], x, y, (x == 0 && y == 0));
                cyc++;
            end
        end
        @(negedge clk);
        tvalid = 1'b0; tuser = 1'b0; tlast = 1'b0; tdata = 1'b0;
        cyc++;
    endtask

    task automatic checkTargets(input string tag, input int p0A, input int p0B);
        modelFinish();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pulsesA > p0A && pulsesB > p0B) break;
        end
        repeat (6) @(negedge clk);
        checkOutput({tag, " readyA"}, 64'(readyBad), 64'd0);
        checkOutput({tag, " pulsesA"}, 64'(pulsesA - p0A), 64'd1);
        checkOutput({tag, " pulsesB"}, 64'(pulsesB - p0B), 64'd1);
        checkOutput({tag, " numA"}, 64'(numA), 64'(expNum[0]));
        checkOutput({tag, " numB"}, 64'(numB), 64'(expNum[1]));
        checkOutput({tag, " ovfA"}, 64'(ovfA), 64'(mOvf));
        checkOutput({tag, " ovfB"}, 64'(ovfB), 64'(mOvf));
        for (int k = 0; k < MAXT; k++) begin
            checkOutput($sformatf("%s slotA%0d", tag, k), 64'(posA[k*EW +: EW]), 64'(expPos[0][k]));
            checkOutput($sformatf("%s slotB%0d", tag, k), 64'(posB[k*EW +: EW]), 64'(expPos[1][k]));
        end
    endtask

    task automatic runFrame(input string tag, input int gapPct);
        int p0A, p0B;
        p0A = pulsesA;
        p0B = pulsesB;
        readyBad = 1'b0;
        applyStimulus(H, gapPct);
        checkTargets(tag, p0A, p0B);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " posA"}, 64'(posA == '0), 64'd1);
        checkOutput({tag, " posB"}, 64'(posB == '0), 64'd1);
        checkOutput({tag, " numA"}, 64'(numA), 64'd0);
        checkOutput({tag, " numB"}, 64'(numB), 64'd0);
        checkOutput({tag, " validA"}, 64'(validA), 64'd0);
        checkOutput({tag, " ovfA"}, 64'(ovfA), 64'd0);
        checkOutput({tag, " ovfB"}, 64'(ovfB), 64'd0);
        checkOutput({tag, " busyA"}, 64'(busyA), 64'd0);
        checkOutput({tag, " readyA"}, 64'(readyA), 64'd0);
        checkOutput({tag, " readyB"}, 64'(readyB), 64'd0);
    endtask

    initial begin
        int p0A, p0B, nr, rw, rh, rx, ry;
        rst = 1'b1; tdata = 1'b0; tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        checkReset("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] single square");
        clearMask(); addRect(16, 8, 19, 11);
        runFrame("square", 0);
        checkOutput("square slot0 const", 64'(posA[0 +: EW]), 64'({1'b1, 7'd11, 7'd19, 7'd8, 7'd16}));

        $display("[TB] two squares, no gaps then random gaps");
        clearMask(); addRect(2, 2, 5, 5); addRect(40, 20, 45, 25);
        runFrame("two", 0);
        checkOutput("two slot1 const", 64'(posA[EW +: EW]), 64'({1'b1, 7'd25, 7'd45, 7'd20, 7'd40}));
        runFrame("two gaps", 35);
        checkOutput("two gaps slot0 const", 64'(posA[0 +: EW]), 64'({1'b1, 7'd5, 7'd5, 7'd2, 7'd2}));

        $display("[TB] pixel chain");
        clearMask(); addRect(10, 5, 30, 5);
        runFrame("chain", 0);
        checkOutput("chain slot0 const", 64'(posA[0 +: EW]), 64'({1'b1, 7'd5, 7'd30, 7'd5, 7'd10}));

        $display("[TB] list overflow then clean frame");
        clearMask();
        for (int i = 0; i < 6; i++) mask[10][5 + 10*i] = 1'b1;
        runFrame("overflow", 0);
        checkOutput("overflow flag const", 64'(ovfA), 64'd1);
        clearMask(); addRect(20, 20, 22, 22);
        runFrame("clean", 0);

        $display("[TB] minimum width filter");
        clearMask(); mask[5][5] = 1'b1; addRect(30, 20, 33, 23);
        runFrame("minw", 0);
        checkOutput("minw slotB1 const", 64'(posB[EW +: EW]), 64'd0);

        $display("[TB] random frames");
        for (int r = 0; r < 3; r++) begin
            clearMask();
            nr = $urandom_range(1, 4);
            for (int i = 0; i < nr; i++) begin
                rw = $urandom_range(1, 5); rh = $urandom_range(1, 5);
                rx = $urandom_range(0, W - rw); ry = $urandom_range(0, H - rh);
                addRect(rx, ry, rx + rw - 1, ry + rh - 1);
            end
            runFrame($sformatf("rand%0d", r), $urandom_range(0, 40));
        end

        $display("[TB] reset in the middle of a frame");
        clearMask(); addRect(8, 1, 12, 3);
        readyBad = 1'b0;
        applyStimulus(5, 0);
        rst = 1'b1;
        @(negedge clk);
        checkReset("midreset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        clearMask(); addRect(33, 14, 36, 17);
        runFrame("after reset", 0);

        $display("[TB] start of frame in the middle of a frame");
        p0A = pulsesA;
        p0B = pulsesB;
        readyBad = 1'b0;
        clearMask(); addRect(50, 2, 53, 5);
        applyStimulus(10, 0);
        clearMask(); addRect(10, 20, 12, 22);
        applyStimulus(H, 0);
        checkTargets("restart", p0A, p0B);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
